march_controller: RTL

March C- sequencing controller for the memory BIST. It drives the control inputs of the address generator (`reset`, `preset`, `en`, `up_down`) and uses its `carry` output to detect the last address of each march element. It issues read and write operations with the correct data background to the memory under test, and compares read data one cycle later. It reports `done` and a sticky `fail` with the location of the first mismatch.

---
 rtl/march_controller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/march_controller.sv
// March C- sequencer for the memory BIST: steps an external address generator through
// six march elements, issues reads/writes, and checks read data one cycle later.
module march_controller #(
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ag_carry,
  output logic          ag_reset,
  output logic          ag_preset,
  output logic          ag_en,
  output logic          ag_up_down,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [dw-1:0] mem_wdata,
  input  logic [dw-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [2:0]    fail_element,
  output logic          fail_op
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic [2:0]  r_elem, w_elem_next;
  logic        r_op, w_op_next;
  logic        w_start_ok;

  logic        r_ag_reset, r_ag_preset, r_ag_en, r_ag_up_down;
  logic        r_mem_cs, r_mem_we, r_wdata_one, r_busy, r_done;

  logic        r_cmp_valid, r_cmp_exp, r_cmp_op;
  logic [2:0]  r_cmp_elem;
  logic        r_fail, r_fail_op;
  logic [2:0]  r_fail_element;

  // Element table: E3 and E4 walk downwards, E0 and E5 have a single op.
  function automatic logic f_up(input logic [2:0] e);
    return !(e == 3'd3 || e == 3'd4);
  endfunction

  function automatic logic f_last(input logic [2:0] e, input logic op);
    return (e == 3'd0 || e == 3'd5) ? 1'b1 : op;
  endfunction

  function automatic logic f_write(input logic [2:0] e, input logic op);
    return (e == 3'd0) || op;
  endfunction

  function automatic logic f_data(input logic [2:0] e, input logic op);
    return op ? (e == 3'd1 || e == 3'd3) : (e == 3'd2 || e == 3'd4);
  endfunction

  assign w_start_ok = (r_state == S_IDLE || r_state == S_DONE) && start;

  always_comb begin
    w_state_next = r_state;
    w_elem_next  = r_elem;
    w_op_next    = r_op;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = S_SETUP;
          w_elem_next  = 3'd0;
          w_op_next    = 1'b0;
        end
      end
      S_SETUP: begin
        w_state_next = S_RUN;
        w_op_next    = 1'b0;
      end
      S_RUN: begin
        if (f_last(r_elem, r_op)) begin
          w_op_next = 1'b0;
          if (ag_carry) begin
            if (r_elem == 3'd5) begin
              w_state_next = S_DRAIN;
            end else begin
              w_state_next = S_SETUP;
              w_elem_next  = r_elem + 3'd1;
            end
          end
        end else begin
          w_op_next = r_op + 1'b1;
        end
      end
      S_DRAIN: w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_elem       <= 3'd0;
      r_op         <= 1'b0;
      r_ag_reset   <= 1'b0;
      r_ag_preset  <= 1'b0;
      r_ag_en      <= 1'b0;
      r_ag_up_down <= 1'b0;
      r_mem_cs     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_wdata_one  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_elem       <= w_elem_next;
      r_op         <= w_op_next;
      r_ag_reset   <= (w_state_next == S_SETUP) && f_up(w_elem_next);
      r_ag_preset  <= (w_state_next == S_SETUP) && !f_up(w_elem_next);
      r_ag_en      <= (w_state_next == S_RUN) && f_last(w_elem_next, w_op_next);
      r_ag_up_down <= (w_state_next == S_SETUP || w_state_next == S_RUN) && f_up(w_elem_next);
      r_mem_cs     <= (w_state_next == S_RUN);
      r_mem_we     <= (w_state_next == S_RUN) && f_write(w_elem_next, w_op_next);
      r_wdata_one  <= (w_state_next == S_RUN) && f_write(w_elem_next, w_op_next)
                      && f_data(w_elem_next, w_op_next);
      r_busy       <= (w_state_next == S_SETUP || w_state_next == S_RUN || w_state_next == S_DRAIN);
      r_done       <= (w_state_next == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmp_valid    <= 1'b0;
      r_cmp_exp      <= 1'b0;
      r_cmp_elem     <= 3'd0;
      r_cmp_op       <= 1'b0;
      r_fail         <= 1'b0;
      r_fail_element <= 3'd0;
      r_fail_op      <= 1'b0;
    end else begin
      r_cmp_valid <= (r_state == S_RUN) && !f_write(r_elem, r_op);
      r_cmp_exp   <= f_data(r_elem, r_op);
      r_cmp_elem  <= r_elem;
      r_cmp_op    <= r_op;
      if (w_start_ok) begin
        r_fail         <= 1'b0;
        r_fail_element <= 3'd0;
        r_fail_op      <= 1'b0;
      end else if (r_cmp_valid && (mem_rdata != {dw{r_cmp_exp}})) begin
        r_fail <= 1'b1;
        if (!r_fail) begin
          r_fail_element <= r_cmp_elem;
          r_fail_op      <= r_cmp_op;
        end
      end
    end
  end

  assign ag_reset     = r_ag_reset;
  assign ag_preset    = r_ag_preset;
  assign ag_en        = r_ag_en;
  assign ag_up_down   = r_ag_up_down;
  assign mem_cs       = r_mem_cs;
  assign mem_we       = r_mem_we;
  assign mem_wdata    = {dw{r_wdata_one}};
  assign busy         = r_busy;
  assign done         = r_done;
  assign fail         = r_fail;
  assign fail_element = r_fail_element;
  assign fail_op      = r_fail_op;

endmodule
